// File: rtl/fft_buf_in64.sv
// fft_buf_in64: ping-pong 64-sample input buffer emitting stride-8 groups for the 8-point FFT core
module fft_buf_in64 #(
  parameter int DATA_WD = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [2*DATA_WD-1:0]     dat_i,
  input  logic                     val_i,
  input  logic                     sop_i,
  output logic                     rdy_o,
  output logic [8*2*DATA_WD-1:0]   dat_o,
  output logic                     val_o,
  input  logic                     rdy_i,
  output logic [2:0]               grp_o,
  output logic                     sof_o,
  output logic                     eof_o
);
  localparam int SW = 2*DATA_WD;
  logic [SW-1:0] mem [2][64];
  logic [1:0]    full;
  logic          wr_sel, rd_sel;
  logic [5:0]    wr_cnt, wa;
  logic [2:0]    rd_cnt;
  logic          wr_go, wr_done, rd_go, rd_done;
  assign rdy_o   = !full[wr_sel];
  assign wr_go   = val_i && rdy_o;
  assign wa      = sop_i ? 6'd0 : wr_cnt;
  assign wr_done = wr_go && wa == 6'd63;
  assign val_o   = full[rd_sel];
  assign rd_go   = val_o && rdy_i;
  assign rd_done = rd_go && rd_cnt == 3'd7;
  assign grp_o   = rd_cnt;
  assign sof_o   = val_o && rd_cnt == 3'd0;
  assign eof_o   = val_o && rd_cnt == 3'd7;
  // lane k of group g is sample g + 8k, i.e. address {k, g}
  for (genvar k = 0; k < 8; k++) begin : g_lane
    assign dat_o[k*SW +: SW] = mem[rd_sel][{3'(k), rd_cnt}];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (wr_go) wr_cnt <= wa + 6'd1;
      if (wr_done) begin
        full[wr_sel] <= 1'b1;
        wr_sel       <= !wr_sel;
      end
      if (rd_go) rd_cnt <= rd_cnt + 3'd1;
      if (rd_done) begin
        full[rd_sel] <= 1'b0;
        rd_sel       <= !rd_sel;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < 64; i++)
          mem[b][i] <= '0;
    end else if (wr_go) begin
      mem[wr_sel][wa] <= dat_i;
    end
  end
endmodule

// File: doc/fft_buf_in64.md
# fft_buf_in64

Input reorder buffer feeding the 8-point FFT core in the 64-point FFT datapath. It accepts complex samples one per cycle over a valid/ready handshake and stores each 64-sample frame in a ping-pong bank. It then emits the frame as eight 8-sample groups, stride-8 ordered, on the parallel bus that the first-stage 8-point core consumes. One bank fills while the other drains, so a continuous input stream runs without stalls.

## Interface

- `DATA_WD`, 16, width of one real or imaginary component (signed, two's complement, same fixed-point format as the core input `DATA_INP_WD`)
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `dat_i`  in  2*DATA_WD  input sample; re = `[2*DATA_WD-1:DATA_WD]`, im = `[DATA_WD-1:0]`
- `val_i`  in  1  `dat_i` valid
- `sop_i`  in  1  first sample of a frame; sampled only when `val_i && rdy_o`
- `rdy_o`  out  1  buffer can accept a sample this cycle
- `dat_o`  out  8*2*DATA_WD  group output; lane k at `[k*2*DATA_WD +: 2*DATA_WD]`, same re/im packing as `dat_i`
- `val_o`  out  1  `dat_o` holds a valid group
- `rdy_i`  in  1  downstream accepts the group
- `grp_o`  out  3  index g (0..7) of the group on `dat_o`
- `sof_o`  out  1  `val_o && grp_o==0`
- `eof_o`  out  1  `val_o && grp_o==7`

## Operation

- Storage: two banks B0 and B1, each with 64 entries of 2*DATA_WD. Per-bank `full` flag. Write pointer `wr_sel` with counter `wr_cnt[5:0]`. Read pointer `rd_sel` with counter `rd_cnt[2:0]`.
- Input transfer occurs when `val_i && rdy_o`. `rdy_o = !full[wr_sel]` (combinational).
- On transfer, sample n = `wr_cnt` is written to entry n of bank `wr_sel`.
  - `sop_i=1` forces n = 0 and then `wr_cnt` = 1. A partial frame in progress is discarded.
  - With n == 63: set `full[wr_sel]`, toggle `wr_sel`, and set `wr_cnt` = 0.
- Samples before the first `sop_i` are written normally from `wr_cnt` = 0. `sop_i` is resynchronisation only, not mandatory.
- Read side:
  - `val_o = full[rd_sel]`, `grp_o = rd_cnt`.
  - Lane k of `dat_o` = entry (g + 8k) of bank `rd_sel`, where g = `rd_cnt`. Example: group 1 = samples 1, 9, 17, …, 57.
- Output transfer occurs when `val_o && rdy_i`.
  - `rd_cnt` increments.
  - At g == 7: clear `full[rd_sel]`, toggle `rd_sel`, and set `rd_cnt` = 0.
- Data is passed unmodified: no scaling, no rounding, width unchanged.
- `dat_o` is driven combinationally from bank storage. When `val_o` = 0 its value is don't-care but stable (reads bank `rd_sel`).
- Banks hold their contents until overwritten. A clear is performed only at reset.

## Timing

- Reset (async assert, sync-safe deassert) sets:
  - `wr_cnt` = 0, `rd_cnt` = 0, `wr_sel` = 0, `rd_sel` = 0, both `full` = 0, all bank entries = 0.
  - Outputs: `rdy_o` = 1, `val_o` = 0, `grp_o` = 0, `sof_o` = 0, `eof_o` = 0, `dat_o` = 0.
- Latency: 64th sample accepted at edge t, so `val_o` = 1 with group 0 in the cycle after edge t (one cycle).
- Drain takes 8 cycles per frame with `rdy_i` held high. Fill takes 64 cycles at full input rate.
- Throughput: with `rdy_i` = 1, `rdy_o` never deasserts for a continuous 1 sample/cycle input.
- Both banks full: `rdy_o` = 0 until the read side frees a bank. The freed bank becomes writable in the cycle after group 7 is accepted.
- Group 7 accepted on the same edge that completes the other bank: `rd_sel` toggles onto the newly full bank. `val_o` stays 1 with no bubble, and `grp_o` = 0 next cycle.
- `rdy_i` low: `dat_o`, `grp_o` and `val_o` hold. The group is never skipped or repeated.
- `sop_i` with `wr_cnt` = 0 has no extra effect.
- `sop_i` on the 64th sample position: the sample becomes entry 0, and the frame does not complete.
- Reset mid-frame: partial and full frames are lost. After release the block behaves as after power-up.

## Test plan

- Ramp frame: samples re = n, im = -n (n = 0..63) at 1/cycle, `rdy_i` = 1 → `val_o` rises 1 cycle after the 64th sample. Group 0 lanes re = {0, 8, …, 56}, group 5 lanes re = {5, 13, …, 61}, `sof_o`/`eof_o` on groups 0/7.
- Back-to-back: 4 frames continuous, `rdy_i` = 1 → `rdy_o` stays 1 throughout, each frame emits exactly 8 groups, no bubble between frames.
- Backpressure: `rdy_i` = 0 for 200 cycles while streaming → after 128 accepted samples `rdy_o` = 0. Raising `rdy_i` drains frame 1 then frame 2 intact, and `rdy_o` reasserts the cycle after the first group 7 transfer.
- Random stalls: random `val_i`/`rdy_i` at 50% → the output groups match a reference transpose for all frames, with no loss or duplication.
- Resync: `sop_i` pulsed at sample 20 of a frame → the first 20 samples are discarded, and the output frame starts from the sample carrying `sop_i`.
- Reset mid-drain: `rst_n` asserted while `grp_o` = 3 → `val_o` = 0, `rdy_o` = 1 and `dat_o` = 0 immediately. The next full frame is emitted correctly.
